// File: rtl/btn_conditioner.sv
// btn_conditioner: four-channel synchronizer and debouncer for active-low pushbuttons.
//   clk                 system clock
//   rst                 synchronous reset, active-high
//   btn_*_raw           raw asynchronous buttons, active-low
//   btn_*               debounced levels, active-low (0 = pressed)
//   press_pulse[3:0]    one-cycle pulse on each accepted press, {abajo, arriba, derecha, izquierda}
//   any_pressed         high while any debounced level is 0
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_izquierda_raw,
  input  logic       btn_derecha_raw,
  input  logic       btn_arriba_raw,
  input  logic       btn_abajo_raw,
  output logic       btn_izquierda,
  output logic       btn_derecha,
  output logic       btn_arriba,
  output logic       btn_abajo,
  output logic [3:0] press_pulse,
  output logic       any_pressed
);

  localparam int unsigned NUM_CH = 4;
  localparam logic [CNT_W-1:0] THRESHOLD = CNT_W'(DEBOUNCE_CYCLES);

  localparam logic [1:0] ST_STABLE_HI = 2'd0;
  localparam logic [1:0] ST_COUNT_LO  = 2'd1;
  localparam logic [1:0] ST_STABLE_LO = 2'd2;
  localparam logic [1:0] ST_COUNT_HI  = 2'd3;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] level_nxt;
  logic [NUM_CH-1:0] pulse_nxt;

  assign raw = {btn_abajo_raw, btn_arriba_raw, btn_derecha_raw, btn_izquierda_raw};

  // Two-flop synchronizer, idle-high so reset looks like "not pressed".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce FSM; the channels never interact.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lvl_nxt;
    logic             pls_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_STABLE_HI;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lvl_nxt   = level[i];
      pls_nxt   = 1'b0;
      case (state)
        ST_STABLE_HI: begin
          if (!sync2[i]) begin
            // A threshold of one accepts the very first differing sample.
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt = ST_STABLE_LO;
              cnt_nxt   = '0;
              lvl_nxt   = 1'b0;
              pls_nxt   = 1'b1;
            end else begin
              state_nxt = ST_COUNT_LO;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_COUNT_LO: begin
          if (sync2[i]) begin
            state_nxt = ST_STABLE_HI;
            cnt_nxt   = '0;
          end else if (cnt == THRESHOLD) begin
            state_nxt = ST_STABLE_LO;
            cnt_nxt   = '0;
            lvl_nxt   = 1'b0;
            pls_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_STABLE_LO: begin
          if (sync2[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt = ST_STABLE_HI;
              cnt_nxt   = '0;
              lvl_nxt   = 1'b1;
            end else begin
              state_nxt = ST_COUNT_HI;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_COUNT_HI: begin
          if (!sync2[i]) begin
            state_nxt = ST_STABLE_LO;
            cnt_nxt   = '0;
          end else if (cnt == THRESHOLD) begin
            state_nxt = ST_STABLE_HI;
            cnt_nxt   = '0;
            lvl_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_STABLE_HI;
          cnt_nxt   = '0;
          lvl_nxt   = 1'b1;
        end
      endcase
    end

    assign level_nxt[i] = lvl_nxt;
    assign pulse_nxt[i] = pls_nxt;
  end

  // any_pressed is derived from the next levels so it moves on the same edge as btn_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      level       <= '1;
      press_pulse <= '0;
      any_pressed <= 1'b0;
    end else begin
      level       <= level_nxt;
      press_pulse <= pulse_nxt;
      any_pressed <= ~&level_nxt;
    end
  end

  assign btn_izquierda = level[0];
  assign btn_derecha   = level[1];
  assign btn_arriba    = level[2];
  assign btn_abajo     = level[3];

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and randomized checks of btn_conditioner against a
// run-length reference model (D = 4, CNT_W = 3).
module tb_btn_conditioner;

  localparam int unsigned D   = 4;
  localparam int unsigned CW  = 3;
  // A change is accepted on the (D+1)-th consecutive differing synchronized sample.
  localparam int          THR = (D == 1) ? 1 : D + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic       btn_izquierda, btn_derecha, btn_arriba, btn_abajo;
  logic [3:0] press_pulse;
  logic       any_pressed;
  logic [3:0] btn_v;

  int errors = 0;
  int checks = 0;
  int pulse_seen [4];

  // Reference model state
  logic [3:0] m_s1, m_s2, m_out, m_pulse;
  logic       m_any;
  int         m_run [4];

  always #5 clk = ~clk;

  assign btn_v = {btn_abajo, btn_arriba, btn_derecha, btn_izquierda};

  btn_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .btn_izquierda_raw (raw[0]),
    .btn_derecha_raw   (raw[1]),
    .btn_arriba_raw    (raw[2]),
    .btn_abajo_raw     (raw[3]),
    .btn_izquierda     (btn_izquierda),
    .btn_derecha       (btn_derecha),
    .btn_arriba        (btn_arriba),
    .btn_abajo         (btn_abajo),
    .press_pulse       (press_pulse),
    .any_pressed       (any_pressed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model one rising edge from the values present just before it.
  task automatic model_edge(input logic [3:0] r_raw, input logic r_rst);
    if (r_rst) begin
      m_s1 = '1; m_s2 = '1; m_out = '1; m_pulse = '0; m_any = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_pulse[i] = 1'b0;
        if (m_s2[i] != m_out[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == THR) begin
          m_out[i]   = m_s2[i];
          m_run[i]   = 0;
          m_pulse[i] = ~m_out[i];
        end
      end
      m_s2  = m_s1;
      m_s1  = r_raw;
      m_any = (m_out != 4'hF);
    end
  endtask

  // One clock: drive, edge, model, compare every output.
  task automatic step(input logic [3:0] r_raw, input logic r_rst);
    raw = r_raw;
    rst = r_rst;
    @(posedge clk);
    model_edge(r_raw, r_rst);
    #1;
    for (int i = 0; i < 4; i++) if (press_pulse[i] === 1'b1) pulse_seen[i]++;
    check("btn_levels", 32'(btn_v), 32'(m_out));
    check("press_pulse", 32'(press_pulse), 32'(m_pulse));
    check("any_pressed", 32'(any_pressed), 32'(m_any));
  endtask

  // Step with a held raw pattern until channel ch reads val; n is the edge count (21 = timeout).
  task automatic wait_level(input int ch, input logic val, input logic [3:0] r_raw, output int n);
    n = 21;
    for (int k = 1; k <= 20; k++) begin
      step(r_raw, 1'b0);
      if (btn_v[ch] === val) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 4; i++) pulse_seen[i] = 0;
  endtask

  initial begin
    int n;
    logic [3:0] r;
    logic rr;
    rst = 1'b1;
    raw = 4'h0;
    clear_seen();
    m_s1 = '1; m_s2 = '1; m_out = '1; m_pulse = '0; m_any = 1'b0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;

    // Reset with all raw inputs low
    step(4'h0, 1'b1);
    step(4'h0, 1'b1);
    check("reset_btn", 32'(btn_v), 32'hF);
    check("reset_pulse", 32'(press_pulse), 32'h0);
    check("reset_any", 32'(any_pressed), 32'h0);
    step(4'h0, 1'b0);
    check("post_reset_btn", 32'(btn_v), 32'hF);
    check("post_reset_any", 32'(any_pressed), 32'h0);
    repeat (10) step(4'hF, 1'b0);

    // Clean press on izquierda: sampled on edge 1, accepted D+2 edges later
    clear_seen();
    wait_level(0, 1'b0, 4'b1110, n);
    check("press_latency", 32'(n), 32'd7);
    check("press_pulse_izq", 32'(press_pulse), 32'b0001);
    check("press_any", 32'(any_pressed), 32'd1);
    step(4'b1110, 1'b0);
    check("pulse_one_cycle", 32'(press_pulse), 32'h0);
    repeat (12) step(4'b1110, 1'b0);
    check("held_pulse_count", 32'(pulse_seen[0]), 32'd1);

    // Release izquierda: no pulse, any_pressed drops with the level
    clear_seen();
    wait_level(0, 1'b1, 4'hF, n);
    check("release_latency", 32'(n), 32'd7);
    check("release_any", 32'(any_pressed), 32'd0);
    check("release_pulse", 32'(press_pulse), 32'h0);
    repeat (4) step(4'hF, 1'b0);
    check("release_no_pulse", 32'(pulse_seen[0]), 32'd0);

    // Bounce on derecha: 3 low, 1 high, 2 low, 1 high, then held low
    clear_seen();
    repeat (3) step(4'b1101, 1'b0);
    step(4'hF, 1'b0);
    repeat (2) step(4'b1101, 1'b0);
    step(4'hF, 1'b0);
    check("bounce_level", 32'(btn_derecha), 32'd1);
    wait_level(1, 1'b0, 4'b1101, n);
    check("bounce_latency", 32'(n), 32'd7);
    check("bounce_pulse", 32'(press_pulse), 32'b0010);
    check("bounce_pulse_count", 32'(pulse_seen[1]), 32'd1);
    wait_level(1, 1'b1, 4'hF, n);
    repeat (4) step(4'hF, 1'b0);

    // Simultaneous derecha+abajo press with a 2-cycle arriba glitch
    clear_seen();
    step(4'b0101, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    wait_level(1, 1'b0, 4'b0101, n);
    check("simul_latency", 32'(n), 32'd4);
    check("simul_pulse", 32'(press_pulse), 32'b1010);
    check("simul_levels", 32'(btn_v), 32'b0101);
    repeat (4) step(4'b0101, 1'b0);
    check("glitch_no_pulse", 32'(pulse_seen[2]), 32'd0);
    repeat (10) step(4'hF, 1'b0);

    // Reset on the 4th edge of an arriba press discards the count
    clear_seen();
    repeat (3) step(4'b1011, 1'b0);
    step(4'b1011, 1'b1);
    check("midreset_level", 32'(btn_arriba), 32'd1);
    wait_level(2, 1'b0, 4'b1011, n);
    check("midreset_latency", 32'(n), 32'd7);
    check("midreset_pulse", 32'(press_pulse), 32'b0100);
    check("midreset_pulse_count", 32'(pulse_seen[2]), 32'd1);
    repeat (10) step(4'hF, 1'b0);

    // Random bouncing on all channels with occasional resets
    r = 4'hF;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      rr = ($urandom_range(0, 149) == 0);
      step(r, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
